// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin share of one fixed-latency memory port among NUM_MASTERS requesters
module imem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        req_valid_i,
    input  logic [NUM_MASTERS-1:0]        req_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] req_wdata_i,
    output logic [NUM_MASTERS-1:0]        req_ready_o,
    output logic [NUM_MASTERS-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic                          busy_o
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, gnt_q, gnt_d, sel;
    logic              we_q, we_d, found;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // First valid requester at or above the pointer, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req_valid_i[(int'(ptr_q) + k) % NUM_MASTERS]) begin
                found = 1'b1;
                sel   = IDX_W'((int'(ptr_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                gnt_d   = sel;
                we_d    = req_we_i[sel];
                addr_d  = req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
                wdata_d = req_wdata_i[int'(sel)*DATA_W +: DATA_W];
                ptr_d   = (sel == LAST) ? '0 : sel + 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                rdata_d = we_q ? '0 : mem_rdata_i;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accept strobe is combinational, so it is masked while reset is held
    assign req_ready_o = (rst_n && state_q == IDLE && found) ? ONE << sel : '0;
    assign rsp_valid_o = (state_q == RESP) ? ONE << gnt_q : '0;
    assign rsp_rdata_o = rdata_q;
    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of the memory arbiter at latency 1 and latency 3
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v, v3, we;
    logic [63:0] addr, wd;
    logic [1:0]  rdy, rsp, rdy3, rsp3;
    logic [31:0] rdata, maddr, mwdata, mrdata, rdata3, maddr3, mwdata3, mrdata3;
    logic        mreq, mwe, busy, mreq3, mwe3, busy3;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(v), .req_we_i(we), .req_addr_i(addr),
        .req_wdata_i(wd), .req_ready_o(rdy), .rsp_valid_o(rsp), .rsp_rdata_o(rdata),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_rdata_i(mrdata), .busy_o(busy)
    );

    imem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(v3), .req_we_i(we), .req_addr_i(addr),
        .req_wdata_i(wd), .req_ready_o(rdy3), .rsp_valid_o(rsp3), .rsp_rdata_o(rdata3),
        .mem_req_o(mreq3), .mem_we_o(mwe3), .mem_addr_o(maddr3), .mem_wdata_o(mwdata3),
        .mem_rdata_i(mrdata3), .busy_o(busy3)
    );

    // Unwritten words read back an address-derived pattern; data is only valid for the one due cycle
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0]  mem1 [0:255];
    logic [255:0] wr1;
    logic [31:0]  p3 [0:2];

    always @(posedge clk) begin
        mrdata <= mreq ? (wr1[maddr[9:2]] ? mem1[maddr[9:2]] : dflt(maddr)) : 32'h0;
        if (!rst_n) wr1 <= '0;
        else if (mreq && mwe) begin
            mem1[maddr[9:2]] <= mwdata;
            wr1[maddr[9:2]]  <= 1'b1;
        end
        p3[0] <= mreq3 ? dflt(maddr3) : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mrdata3 = p3[2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One full transaction on the latency-1 arbiter: accept, issue, wait, response
    task automatic xact(input string tag, input logic [1:0] vv, input logic hold, input logic [1:0] g,
                        input logic [31:0] a, input logic w, input logic [31:0] d, input logic [31:0] r);
        tick; v = vv; #1;
        chk({tag, "_ready"}, rdy, g);
        chk({tag, "_idle_busy"}, busy, 0);
        tick; if (!hold) v = 2'b00; #1;
        chk({tag, "_mreq"}, mreq, 1);
        chk({tag, "_maddr"}, maddr, a);
        chk({tag, "_mwe"}, mwe, w);
        chk({tag, "_mwdata"}, mwdata, d);
        chk({tag, "_ready_issue"}, rdy, 0);
        chk({tag, "_busy"}, busy, 1);
        tick; #1;
        chk({tag, "_rsp_wait"}, rsp, 0);
        chk({tag, "_mreq_wait"}, mreq, 0);
        chk({tag, "_maddr_wait"}, maddr, 0);
        chk({tag, "_ready_wait"}, rdy, 0);
        tick; #1;
        chk({tag, "_rsp"}, rsp, g);
        chk({tag, "_rdata"}, rdata, r);
        chk({tag, "_ready_resp"}, rdy, 0);
    endtask

    initial begin
        rst_n = 1'b0; v = 2'b00; v3 = 2'b00; we = 2'b00; addr = '0; wd = '0;
        repeat (2) tick;
        v = 2'b11; v3 = 2'b11; #1;
        chk("rst_ready", rdy, 0);
        chk("rst_ready3", rdy3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mreq", mreq, 0);
        chk("rst_rsp", rsp, 0);
        chk("rst_rdata", rdata, 0);
        tick; rst_n = 1'b1; v = 2'b00; v3 = 2'b00;

        addr[31:0] = 32'h100;
        xact("rd0", 2'b01, 1'b0, 2'b01, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
        tick; #1;
        chk("rd0_done_busy", busy, 0);
        chk("rd0_done_rsp", rsp, 0);
        chk("rd0_hold_rdata", rdata, 32'hDEADBEEF);

        addr[63:32] = 32'h20; wd[63:32] = 32'h12345678; we = 2'b10;
        xact("wr1", 2'b10, 1'b0, 2'b10, 32'h20, 1'b1, 32'h12345678, 32'h0);
        we = 2'b00;
        xact("rdback1", 2'b10, 1'b0, 2'b10, 32'h20, 1'b0, 32'h12345678, 32'h12345678);

        addr[63:32] = 32'h104; wd = '0;
        for (int i = 0; i < 4; i++)
            xact("rr", 2'b11, 1'b1, (i % 2) ? 2'b10 : 2'b01, (i % 2) ? 32'h104 : 32'h100, 1'b0, 32'h0,
                 (i % 2) ? 32'h0104FEFB : 32'hDEADBEEF);
        v = 2'b00;

        tick; v = 2'b01; #1;
        chk("late_ready0", rdy, 2'b01);
        tick; v = 2'b00;
        tick; v = 2'b10; #1;
        chk("late_ready_wait", rdy, 0);
        tick; #1;
        chk("late_ready_resp", rdy, 0);
        chk("late_rsp0", rsp, 2'b01);
        tick; #1;
        chk("late_ready1", rdy, 2'b10);
        tick; v = 2'b00;
        tick;
        tick; #1;
        chk("late_rsp1", rsp, 2'b10);
        chk("late_rdata1", rdata, 32'h0104FEFB);

        tick; v = 2'b01; #1;
        chk("mid_ready", rdy, 2'b01);
        tick; v = 2'b00;
        tick; rst_n = 1'b0; v = 2'b11; #1;
        chk("mid_busy", busy, 0);
        chk("mid_ready_rst", rdy, 0);
        chk("mid_rsp", rsp, 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_mreq", mreq, 0);
        tick; rst_n = 1'b1; #1;
        chk("post_rst_grant", rdy, 2'b01);
        tick; v = 2'b00; #1;
        chk("post_rst_rsp_a", rsp, 0);
        tick; #1;
        chk("post_rst_rsp_b", rsp, 0);
        tick; #1;
        chk("post_rst_rsp", rsp, 2'b01);
        chk("post_rst_rdata", rdata, 32'hDEADBEEF);

        tick; v3 = 2'b01; #1;
        chk("lat3_ready", rdy3, 2'b01);
        chk("lat3_busy_t", busy3, 0);
        tick; v3 = 2'b00; #1;
        chk("lat3_mreq", mreq3, 1);
        chk("lat3_maddr", maddr3, 32'h100);
        chk("lat3_busy_t1", busy3, 1);
        for (int k = 0; k < 3; k++) begin
            tick; #1;
            chk("lat3_wait_busy", busy3, 1);
            chk("lat3_wait_rsp", rsp3, 0);
            chk("lat3_wait_mreq", mreq3, 0);
        end
        tick; #1;
        chk("lat3_rsp", rsp3, 2'b01);
        chk("lat3_rdata", rdata3, 32'hDEADBEEF);
        chk("lat3_busy_t5", busy3, 1);
        tick; #1;
        chk("lat3_idle_busy", busy3, 0);
        chk("lat3_idle_rsp", rsp3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one instruction/data memory port between NUM_MASTERS core fetch or load/store requesters in the multicore build.
- Sits between the per-core memory interfaces and the single memory array.
- Accepts one request at a time using round-robin arbitration with a valid/ready handshake.
- Drives a fixed-latency memory, captures the read data and returns it to the granted requester as a one-cycle response pulse.

Parameters:
- NUM_MASTERS, 2, number of requesters (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_req cycle to the cycle mem_rdata is valid (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_MASTERS  per-requester request valid.
- req_we  input  NUM_MASTERS  per-requester write enable (1 = write).
- req_addr  input  NUM_MASTERS*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_MASTERS*DATA_W  packed write data, same slicing.
- req_ready  output  NUM_MASTERS  one-hot accept strobe.
- rsp_valid  output  NUM_MASTERS  one-hot one-cycle response strobe.
- rsp_rdata  output  DATA_W  response data, shared by all requesters, qualified by rsp_valid.
- mem_req  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_req.
- busy  output  1  high whenever the arbiter is not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, round-robin pointer=0, all outputs 0. Any in-flight transaction is dropped and produces no response.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant g = first set bit searching from the pointer upward, wrapping modulo NUM_MASTERS.
  - req_ready[g]=1 combinationally in the same cycle. This is the accept.
  - Latch g, req_we[g], req_addr[g] and req_wdata[g]. Set pointer=(g+1) mod NUM_MASTERS. Go to ISSUE.
  - With no req_valid: stay in IDLE, all strobes 0.
- ISSUE (1 cycle):
  - mem_req=1, with mem_we/mem_addr/mem_wdata driven from the latched values.
  - Load the latency counter with MEM_LATENCY-1. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, register mem_rdata into rsp_rdata for a read, or 0 for a write. Go to RESP.
  - MEM_LATENCY=1 gives exactly one WAIT cycle.
- RESP (1 cycle):
  - rsp_valid[g]=1; rsp_rdata holds its value until the next RESP.
  - Go to IDLE.
- Timing: accept at cycle T, mem_req at T+1, rdata sampled at T+1+MEM_LATENCY, rsp_valid at T+2+MEM_LATENCY. The next accept is possible no earlier than T+3+MEM_LATENCY.
- mem_addr, mem_we and mem_wdata are 0 whenever mem_req=0.
- Requester rules:
  - Hold req_valid and payload stable until req_ready.
  - A withdrawn request is simply never granted.
  - Payload is sampled only in the accept cycle.
  - req_valid asserted during ISSUE/WAIT/RESP is ignored until IDLE.
- Writes complete with an rsp_valid acknowledge; rsp_rdata=0 for writes.
- At most one bit of req_ready and at most one bit of rsp_valid is set in any cycle. rsp_valid goes only to the requester that was accepted.
- busy = (state != IDLE).

Test Plan:
- Single read: master0 valid, addr=0x100, memory word 0xDEADBEEF, MEM_LATENCY=1. Required: req_ready[0] at T, mem_req at T+1 with mem_addr=0x100, rsp_valid[0] at T+3 with rsp_rdata=0xDEADBEEF.
- Contention: masters 0 and 1 both hold valid continuously for 4 transactions. Required: grant order 0,1,0,1, and never two ready bits in one cycle.
- Write acknowledge: master1 write addr=0x20, wdata=0x12345678. Required: mem_req with mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; then rsp_valid[1] with rsp_rdata=0; a subsequent read of 0x20 returns 0x12345678.
- Latency parameter: MEM_LATENCY=3, read accepted at T. Required: mem_req at T+1, rsp_valid at T+5; busy high from T+1 through T+5.
- Reset mid-operation: assert rst_n=0 during WAIT. Required: all outputs 0 immediately, no rsp_valid afterwards, and after release the first grant goes to master0 when both masters are valid.
- Late request: master1 raises valid during master0's WAIT. Required: master1 is accepted in the first IDLE cycle after master0's RESP.
